fir_coef_ctrl: RTL and testbench

FIR_COEF_CTRL -- requirements
Module: fir_coef_ctrl

---
 rtl/fir_pkg.sv | 19 +
 rtl/coef_bank.sv | 35 +++
 rtl/fir_coef_ctrl.sv | 137 +++++++++++++
 tb/tb_fir_coef_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and widths for the FIR coefficient double-buffer controller.
// The controller FSM states and the coefficient/sample word widths live here.
package fir_pkg;

  localparam int COEF_W = 16;
  localparam int SAMP_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2
  } fir_state_e;

  // Bits needed to hold any value in 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/coef_bank.sv
// One coefficient bank: TAPS words with a single write port and a flat read-out.
// Reset clears every word so a freshly reset bank presents all-zero taps.
module coef_bank
  import fir_pkg::*;
#(
  parameter int TAPS = 201,
  parameter int AW   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [COEF_W-1:0]      wdata,
  output logic [TAPS*COEF_W-1:0] flat
);

  localparam logic [AW-1:0] ADDR_END = AW'(TAPS);

  logic [COEF_W-1:0] regs [TAPS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr < ADDR_END)) begin
      regs[waddr] <= wdata;
    end
  end

  for (genvar g = 0; g < TAPS; g++) begin : g_flat
    assign flat[g*COEF_W +: COEF_W] = regs[g];
  end

endmodule

// File: rtl/fir_coef_ctrl.sv
// Double-buffered FIR coefficient loader: fills the shadow bank, then on commit
// drains the FIR pipeline and swaps banks so coef_flat never changes mid-sample.
module fir_coef_ctrl
  import fir_pkg::*;
#(
  parameter int TAPS = 201,
  parameter int LAT  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [COEF_W-1:0]      cfg_data,
  input  logic                   cfg_commit,
  output logic                   cfg_err,
  output logic                   swap_done,
  output logic                   active_bank,
  input  logic                   smp_valid,
  output logic                   smp_ready,
  input  logic [SAMP_W-1:0]      smp_data,
  output logic                   fir_in_valid,
  output logic [SAMP_W-1:0]      fir_in_sample,
  output logic [TAPS*COEF_W-1:0] coef_flat,
  output logic [1:0]             state_dbg
);

  localparam int PW = cnt_width(TAPS);
  localparam int CW = cnt_width(LAT + 1);
  localparam logic [PW-1:0] WPTR_FULL  = PW'(TAPS);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(LAT + 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  fir_state_e state, state_nxt;
  logic [PW-1:0] wptr;
  logic [CW-1:0] drain_cnt;

  logic is_idle;
  logic cfg_acc;
  logic smp_acc;
  logic commit_ok;
  logic commit_bad;

  logic                   we0, we1;
  logic [TAPS*COEF_W-1:0] flat0, flat1;

  // Handshakes: a word/sample transfers on a rising edge where valid && ready
  // are both high; ready depends only on state/wptr/rst, never on valid.
  assign is_idle    = (state == ST_IDLE);
  assign cfg_ready  = is_idle && (wptr < WPTR_FULL) && rst;
  assign smp_ready  = is_idle && rst;
  assign cfg_acc    = cfg_valid && cfg_ready;
  assign smp_acc    = smp_valid && smp_ready;
  assign commit_ok  = is_idle && cfg_commit && (wptr == WPTR_FULL);
  assign commit_bad = is_idle && cfg_commit && (wptr != WPTR_FULL);
  assign state_dbg  = state;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (commit_ok) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_cnt <= CNT_ONE) state_nxt = ST_SWAP;
      ST_SWAP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (commit_ok) begin
        drain_cnt <= DRAIN_LOAD;
      end else if ((state == ST_DRAIN) && (drain_cnt != '0)) begin
        drain_cnt <= drain_cnt - CNT_ONE;
      end
    end
  end

  // Write pointer and bank select move together so a swap always exposes a
  // completely written bank and restarts filling the other one from tap 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr        <= '0;
      active_bank <= 1'b0;
      swap_done   <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      swap_done <= (state == ST_SWAP);
      cfg_err   <= commit_bad;
      if (state == ST_SWAP) begin
        wptr        <= '0;
        active_bank <= ~active_bank;
      end else if (cfg_acc) begin
        wptr <= wptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fir_in_valid  <= 1'b0;
      fir_in_sample <= '0;
    end else begin
      fir_in_valid <= smp_acc;
      if (smp_acc) begin
        fir_in_sample <= smp_data;
      end
    end
  end

  // Only the shadow bank (the one not driving coef_flat) is ever written.
  assign we0 = cfg_acc && active_bank;
  assign we1 = cfg_acc && !active_bank;

  coef_bank #(.TAPS(TAPS), .AW(PW)) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (we0),
    .waddr (wptr),
    .wdata (cfg_data),
    .flat  (flat0)
  );

  coef_bank #(.TAPS(TAPS), .AW(PW)) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (we1),
    .waddr (wptr),
    .wdata (cfg_data),
    .flat  (flat1)
  );

  assign coef_flat = active_bank ? flat1 : flat0;

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Self-checking bench for fir_coef_ctrl: a cycle-level reference model tracks
// the two banks, the write pointer and the LAT+2 busy window after a commit.
module tb_fir_coef_ctrl;

  localparam int TAPS = 201;
  localparam int LAT  = 5;
  localparam int BUSY = LAT + 2;

  logic                 clk;
  logic                 rst;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [15:0]          cfg_data;
  logic                 cfg_commit;
  logic                 cfg_err;
  logic                 swap_done;
  logic                 active_bank;
  logic                 smp_valid;
  logic                 smp_ready;
  logic [15:0]          smp_data;
  logic                 fir_in_valid;
  logic [15:0]          fir_in_sample;
  logic [TAPS*16-1:0]   coef_flat;
  logic [1:0]           state_dbg;

  fir_coef_ctrl #(.TAPS(TAPS), .LAT(LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_data      (cfg_data),
    .cfg_commit    (cfg_commit),
    .cfg_err       (cfg_err),
    .swap_done     (swap_done),
    .active_bank   (active_bank),
    .smp_valid     (smp_valid),
    .smp_ready     (smp_ready),
    .smp_data      (smp_data),
    .fir_in_valid  (fir_in_valid),
    .fir_in_sample (fir_in_sample),
    .coef_flat     (coef_flat),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  int  mbank [2][TAPS];
  int  mactive;
  int  mwptr;
  int  busy;
  bit  err_pend;
  bit  swap_pend;
  logic [15:0] exp_q[$];
  int  gaps_q[$];
  bit  stream_on;
  bit  seen_valid;
  int  gap_run;
  logic [15:0] next_samp;
  int  err_seen, swap_seen, ready_low;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int t = 0; t < TAPS; t++) mbank[b][t] = 0;
    mactive   = 0;
    mwptr     = 0;
    busy      = 0;
    err_pend  = 0;
    swap_pend = 0;
    exp_q.delete();
  endtask

  function automatic logic [TAPS*16-1:0] model_flat();
    logic [TAPS*16-1:0] v;
    for (int t = 0; t < TAPS; t++) v[t*16 +: 16] = 16'(mbank[mactive][t]);
    return v;
  endfunction

  task automatic check_flat(input string tag);
    logic [TAPS*16-1:0] e;
    int first;
    e = model_flat();
    n_assert++;
    assert (coef_flat === e) else begin
      n_fail++;
      first = -1;
      for (int t = TAPS - 1; t >= 0; t--)
        if (coef_flat[t*16 +: 16] !== e[t*16 +: 16]) first = t;
      $error("FAIL %s: tap %0d observed %0h expected %0h", tag, first,
             coef_flat[first*16 +: 16], e[first*16 +: 16]);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: checks outputs, drives inputs, advances the model
  // across the next rising edge and returns at the following falling edge.
  task automatic step(input logic cv, input logic [15:0] cd, input logic cm, output bit acc);
    bit exp_cr, exp_sr, sacc;
    logic sv;
    logic [15:0] sd;
    exp_cr = (busy == 0) && (mwptr < TAPS);
    exp_sr = (busy == 0);
    check("cfg_ready", cfg_ready, exp_cr);
    check("smp_ready", smp_ready, exp_sr);
    check("cfg_err", cfg_err, err_pend);
    check("swap_done", swap_done, swap_pend);
    check("active_bank", active_bank, mactive);
    if (cfg_err) err_seen++;
    if (swap_done) swap_seen++;
    if (!smp_ready) ready_low++;
    if (stream_on) begin
      sv = 1'b1;
      sd = next_samp;
    end else begin
      sv = 1'($urandom_range(0, 1));
      sd = 16'($urandom);
    end
    cfg_valid = cv; cfg_data = cd; cfg_commit = cm;
    smp_valid = sv; smp_data = sd;
    acc  = cv && exp_cr;
    sacc = sv && exp_sr;
    err_pend  = (busy == 0) && cm && (mwptr < TAPS);
    swap_pend = (busy == 1);
    if (busy == 1) begin
      mactive = 1 - mactive;
      mwptr   = 0;
    end
    if (busy > 0) busy--;
    else if (cm && mwptr == TAPS) busy = BUSY;
    if (acc) begin
      mbank[1 - mactive][mwptr] = int'(cd);
      mwptr++;
    end
    if (sacc) begin
      exp_q.push_back(sd);
      if (stream_on) next_samp++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_words(input int n, input bit seq);
    int done;
    bit a;
    logic [15:0] d;
    done = 0;
    for (int k = 0; k < 4 * n + 50 && done < n; k++) begin
      d = seq ? 16'(mwptr) : 16'($urandom);
      step(1'($urandom_range(0, 3) != 0), d, 1'b0, a);
      if (a) done++;
    end
    check("write_count", done, n);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int k = 0; k < n; k++) step(1'b0, 16'h0, 1'b0, a);
  endtask

  task automatic clear_counts();
    err_seen = 0; swap_seen = 0; ready_low = 0;
  endtask

  // ---------------- scoreboard for the sample path ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (fir_in_valid) begin
        if (stream_on && seen_valid && gap_run > 0) gaps_q.push_back(gap_run);
        gap_run    = 0;
        seen_valid = 1;
        check("fir_sample_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("fir_in_sample", fir_in_sample, exp_q.pop_front());
      end else begin
        gap_run++;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bit a;
    logic [15:0] v100;
    rst = 1'b0; cfg_valid = 0; cfg_data = 0; cfg_commit = 0;
    smp_valid = 0; smp_data = 0;
    stream_on = 0; seen_valid = 0; gap_run = 0; next_samp = 16'd1;
    model_reset();
    clear_counts();
    repeat (3) @(negedge clk);

    // reset state
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_smp_ready", smp_ready, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_swap_done", swap_done, 0);
    check("rst_active_bank", active_bank, 0);
    check("rst_fir_in_valid", fir_in_valid, 0);
    check("rst_fir_in_sample", fir_in_sample, 0);
    check_flat("rst_coef_flat");
    rst = 1'b1;
    @(negedge clk);
    check("rel_cfg_ready", cfg_ready, 1);
    check("rel_smp_ready", smp_ready, 1);

    // full load data=i then commit
    write_words(TAPS, 1'b1);
    check("full_cfg_ready", cfg_ready, 0);
    check_flat("full_flat_unchanged");
    clear_counts();
    step(1'b0, 16'h0, 1'b1, a);
    idle(12);
    check("a_ready_low", ready_low, BUSY);
    check("a_swap_pulses", swap_seen, 1);
    check("a_err_pulses", err_seen, 0);
    check("a_active_bank", active_bank, 1);
    check("a_tap200", coef_flat[200*16 +: 16], 200);
    check("a_tap0", coef_flat[15:0], 0);
    check_flat("a_flat");

    // premature commit after 100 words
    write_words(100, 1'b0);
    clear_counts();
    step(1'b0, 16'h0, 1'b1, a);
    idle(3);
    check("b_err_pulses", err_seen, 1);
    check("b_swap_pulses", swap_seen, 0);
    check("b_ready_low", ready_low, 0);
    v100 = 16'($urandom);
    step(1'b1, v100, 1'b0, a);
    write_words(TAPS - 101, 1'b0);
    step(1'b0, 16'h0, 1'b1, a);
    idle(12);
    check("b_tap100", coef_flat[100*16 +: 16], v100);
    check_flat("b_flat");

    // commit on the final write, then commit again; source streams 1,2,3,...
    stream_on = 1;
    gaps_q.delete();
    seen_valid = 0;
    write_words(TAPS - 1, 1'b0);
    clear_counts();
    step(1'b1, 16'($urandom), 1'b1, a);
    step(1'b0, 16'h0, 1'b1, a);
    idle(12);
    check("c_err_pulses", err_seen, 1);
    check("c_swap_pulses", swap_seen, 1);
    check("c_ready_low", ready_low, BUSY);
    check("c_gap_count", gaps_q.size(), 1);
    check("c_gap_len", (gaps_q.size() > 0) ? gaps_q[0] : -1, BUSY);
    check_flat("c_flat");
    stream_on = 0;
    cfg_valid = 0; cfg_commit = 0; smp_valid = 0;
    repeat (2) @(negedge clk);
    check("c_samples_drained", exp_q.size(), 0);

    // reset on the third DRAIN cycle abandons the swap
    write_words(TAPS, 1'b0);
    step(1'b0, 16'h0, 1'b1, a);
    idle(2);
    check("d_in_drain", smp_ready, 0);
    rst = 1'b0;
    #1;
    model_reset();
    check("d_active_bank", active_bank, 0);
    check("d_cfg_ready", cfg_ready, 0);
    check("d_smp_ready", smp_ready, 0);
    check("d_swap_done", swap_done, 0);
    check("d_fir_in_valid", fir_in_valid, 0);
    check_flat("d_flat_zero");
    cfg_valid = 0; cfg_commit = 0; smp_valid = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clear_counts();
    idle(12);
    check("d_swap_pulses", swap_seen, 0);
    check("d_ready_low", ready_low, 0);
    check_flat("d_flat_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
